// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor: branch type encoding
// (common with the branch condition unit and decoder) and 2-bit counter states.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_NONE = 3'b010,
        BR_JUMP = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_type_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter,
// shared by all BTB entries since only one entry is trained per cycle.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_state_t ctr,
    input  logic       inc,
    output ctr_state_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            SNT: ctr_next = inc ? WNT : SNT;
            WNT: ctr_next = inc ? WT  : SNT;
            WT:  ctr_next = inc ? ST  : WNT;
            ST:  ctr_next = inc ? ST  : WT;
            default: ctr_next = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts fetch direction/target in the
// same cycle, trains from execute, and raises a registered redirect on mispredicts.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        e_valid,
    input  logic [31:0] e_pc,
    input  logic [2:0]  e_br_type,
    input  logic        e_taken,
    input  logic [31:0] e_target,
    input  logic        e_pred_taken,
    input  logic [31:0] e_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    ctr_state_t          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_BITS-1:0] f_tag, e_tag;
    logic                e_hit, do_update, eff_taken, wrong;
    ctr_state_t          ctr_upd;

    assign f_idx = f_pc[IDX_BITS+1:2];
    assign f_tag = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign e_idx = e_pc[IDX_BITS+1:2];
    assign e_tag = e_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // Reads see the table as it was before this cycle's training write.
    assign pred_hit    = f_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    assign pred_taken  = pred_hit & ctr_q[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : seq_pc(f_pc);

    assign e_hit     = valid_q[e_idx] & (tag_q[e_idx] == e_tag);
    assign do_update = e_valid & (e_br_type != BR_NONE);

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_q[e_idx]),
        .inc      (e_taken),
        .ctr_next (ctr_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (do_update) begin
            valid_q[e_idx] <= 1'b1;
            if (e_hit) begin
                ctr_q[e_idx] <= ctr_upd;
            end else begin
                ctr_q[e_idx] <= e_taken ? WT : WNT;
            end
        end
    end

    // A not-taken resolution on a hit keeps the last known taken target.
    always_ff @(posedge clk) begin
        if (do_update) begin
            tag_q[e_idx] <= e_tag;
            if (!e_hit || e_taken) begin
                target_q[e_idx] <= e_target;
            end
        end
    end

    // Non-branches can never be taken, so a stale taken prediction falls through.
    assign eff_taken = e_taken & (e_br_type != BR_NONE);
    assign wrong     = (eff_taken != e_pred_taken) |
                       (eff_taken & (e_target != e_pred_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            mispred_count <= '0;
        end else begin
            mispredict <= e_valid & wrong;
            if (e_valid && wrong) begin
                redirect_pc <= eff_taken ? e_target : seq_pc(e_pc);
                if (mispred_count != 32'hFFFF_FFFF) begin
                    mispred_count <= mispred_count + 32'd1;
                end
            end
        end
    end

endmodule
